// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// Bridges the cache's 256-bit line port to a 64-bit burst memory interface.
// A line fill or writeback is carried out as four ascending 64-bit beats
// (beat 0 = bits [63:0], beat 3 = bits [255:192]). A fill is reassembled
// into a full line, and either request type finishes with a one-cycle
// line_resp_o pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   line_read_i/line_write_i cache fill / writeback request, held until response
//   line_addr_i              line address, low five bits ignored
//   line_i                   line to write back, captured at acceptance
//   line_o                   assembled fill line, holds until the next fill
//   line_resp_o              one-cycle completion pulse
//   mem_addr_o               line-aligned address latched at acceptance
//   mem_read_o/mem_write_o   burst read / write request toward memory
//   mem_burst_i/mem_burst_o  read beat data in / write beat data out
//   mem_resp_i               beat strobe: read data valid or write beat taken
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_read_i,
    input  logic         line_write_i,
    input  logic [31:0]  line_addr_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         line_resp_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    input  logic [63:0]  mem_burst_i,
    output logic [63:0]  mem_burst_o,
    input  logic         mem_resp_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DONE,
        WR,
        WR_DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   beat_q;
    logic [26:0]  addr_q;
    logic [255:0] wline_q;
    logic [255:0] rline_q;

    // The byte offset within a line carries no meaning here.
    logic         addr_offset_unused;
    assign addr_offset_unused = ^line_addr_i[4:0];

    // State register plus the datapath it steers. The address and writeback
    // line are captured only in IDLE, so anything the cache does to its inputs
    // afterwards cannot disturb the burst in flight. Fill beats land directly
    // in the output line register; a reset clears any partial fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            addr_q  <= 27'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (line_write_i) begin
                        addr_q  <= line_addr_i[31:5];
                        wline_q <= line_i;
                        beat_q  <= 2'd0;
                    end else if (line_read_i) begin
                        addr_q  <= line_addr_i[31:5];
                        beat_q  <= 2'd0;
                    end
                end
                RD: begin
                    if (mem_resp_i) begin
                        rline_q[{beat_q, 6'b0} +: 64] <= mem_burst_i;
                        beat_q <= beat_q + 2'd1;
                    end
                end
                WR: begin
                    if (mem_resp_i) begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and control decode. Writeback wins if the cache ever raises
    // both requests. The burst ends on the strobe that completes beat 3, and
    // the DONE states are single cycles that always fall back to IDLE.
    always_comb begin
        state_d     = state_q;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        line_resp_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_write_i) begin
                    state_d = WR;
                end else if (line_read_i) begin
                    state_d = RD;
                end
            end
            RD: begin
                mem_read_o = 1'b1;
                if (mem_resp_i && (beat_q == 2'd3)) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                line_resp_o = 1'b1;
                state_d     = IDLE;
            end
            WR: begin
                mem_write_o = 1'b1;
                if (mem_resp_i && (beat_q == 2'd3)) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                line_resp_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr_o  = {addr_q, 5'b0};
    assign line_o      = rline_q;
    assign mem_burst_o = wline_q[{beat_q, 6'b0} +: 64];

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
// Self-checking bench for cacheline_adapter. A transaction-level model of
// the adapter runs alongside the DUT and a compare process checks every
// output on every falling edge. Directed scenarios add literal expectations;
// a randomized phase then exercises fills, writebacks, stalls and resets.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic         line_read_i;
    logic         line_write_i;
    logic [31:0]  line_addr_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         line_resp_o;
    logic [31:0]  mem_addr_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_burst_i;
    logic [63:0]  mem_burst_o;
    logic         mem_resp_i;

    int checks   = 0;
    int failures = 0;

    cacheline_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_addr_i  (line_addr_i),
        .line_i       (line_i),
        .line_o       (line_o),
        .line_resp_o  (line_resp_o),
        .mem_addr_o   (mem_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_burst_i  (mem_burst_i),
        .mem_burst_o  (mem_burst_o),
        .mem_resp_i   (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: a request is either absent, in progress with
    // some number of beats already moved, or just completed.
    bit           m_valid = 1'b0;
    bit           m_active;
    bit           m_write;
    bit           m_resp_now;
    int           m_beats;
    logic [31:0]  m_addr;
    logic [255:0] m_wline;
    logic [255:0] m_line_out;

    function automatic logic [255:0] insertBeat(input logic [255:0] line,
                                                input int k,
                                                input logic [63:0] beat);
        logic [255:0] r;
        r = line;
        r[k*64 +: 64] = beat;
        return r;
    endfunction

    function automatic logic [255:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance the model on each rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b1;
            m_active   <= 1'b0;
            m_write    <= 1'b0;
            m_resp_now <= 1'b0;
            m_beats    <= 0;
            m_addr     <= 32'd0;
            m_wline    <= 256'd0;
            m_line_out <= 256'd0;
        end else if (m_resp_now) begin
            m_resp_now <= 1'b0;
        end else if (!m_active) begin
            if (line_write_i || line_read_i) begin
                m_active <= 1'b1;
                m_write  <= line_write_i;
                m_beats  <= 0;
                m_addr   <= {line_addr_i[31:5], 5'b0};
                if (line_write_i) m_wline <= line_i;
            end
        end else if (mem_resp_i) begin
            if (!m_write) m_line_out <= insertBeat(m_line_out, m_beats, mem_burst_i);
            if (m_beats == 3) begin
                m_active   <= 1'b0;
                m_resp_now <= 1'b1;
                m_beats    <= 0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model away from the rising edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("line_resp_o", {255'd0, line_resp_o}, {255'd0, m_resp_now});
            checkOutput("mem_read_o",  {255'd0, mem_read_o},  {255'd0, m_active && !m_write});
            checkOutput("mem_write_o", {255'd0, mem_write_o}, {255'd0, m_active && m_write});
            checkOutput("mem_addr_o",  {224'd0, mem_addr_o},  {224'd0, m_addr});
            checkOutput("line_o",      line_o,                m_line_out);
            if (m_active && m_write)
                checkOutput("mem_burst_o", {192'd0, mem_burst_o}, {192'd0, m_wline[m_beats*64 +: 64]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [255:0] line);
        line_read_i  = rd;
        line_write_i = wr;
        line_addr_i  = addr;
        line_i       = line;
    endtask

    // Drive four contiguous read beats of value base*(k+1) replicated.
    task automatic contigBeats(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            mem_resp_i  = 1'b1;
            mem_burst_i = {4{16'(base * (k + 1))}};
            tick();
        end
        mem_resp_i = 1'b0;
    endtask

    function automatic logic [255:0] bytePattern();
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    // One randomized transaction, optionally aborted by reset partway through.
    task automatic runRandomTxn();
        bit done;
        int cyc;
        bit doAbort;
        int abortAt;
        logic wr;
        wr      = 1'($urandom_range(0, 1));
        doAbort = ($urandom_range(0, 7) == 0);
        abortAt = $urandom_range(1, 6);
        applyStimulus(!wr || ($urandom_range(0, 3) == 0), wr, $urandom, randLine());
        tick();
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            mem_resp_i  = 1'($urandom_range(0, 1));
            mem_burst_i = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                line_i      = randLine();
                line_addr_i = $urandom;
            end
            if (doAbort && cyc == abortAt) begin
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, line_addr_i, line_i);
                tick();
                rst = 1'b0;
                done = 1'b1;
            end else begin
                tick();
                if (line_resp_o) begin
                    applyStimulus(1'b0, 1'b0, line_addr_i, line_i);
                    mem_resp_i = 1'($urandom_range(0, 1));
                    tick();
                    done = 1'b1;
                end
            end
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL random_txn_completion actual=timeout required=line_resp_o");
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        mem_resp_i = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        logic [255:0] pat;
        logic [255:0] lineA;
        int acc;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        mem_resp_i  = 1'b0;
        mem_burst_i = 64'd0;
        tick();
        tick();
        checkOutput("reset_line_o",   line_o, 256'd0);
        checkOutput("reset_addr",     {224'd0, mem_addr_o}, 256'd0);
        checkOutput("reset_burst",    {192'd0, mem_burst_o}, 256'd0);
        checkOutput("reset_ctrl",     {253'd0, mem_read_o, mem_write_o, line_resp_o}, 256'd0);
        rst = 1'b0;
        tick();

        $display("[TB] read fill");
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'd0);
        tick();
        checkOutput("fill_mem_read", {255'd0, mem_read_o}, 256'd1);
        checkOutput("fill_addr", {224'd0, mem_addr_o}, {224'd0, 32'h0000_1220});
        contigBeats(16'h1111);
        checkOutput("fill_resp_cycle6", {255'd0, line_resp_o}, 256'd1);
        checkOutput("fill_line", line_o, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        tick();
        checkOutput("fill_resp_one_cycle", {255'd0, line_resp_o}, 256'd0);

        $display("[TB] writeback with gaps");
        pat = bytePattern();
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, pat);
        acc = 0;
        for (int c = 1; c <= 10; c++) begin
            mem_resp_i = (c == 2 || c == 5 || c == 6 || c == 9);
            if (c == 1) tick();
            if (c < 10) begin
                checkOutput("wb_burst", {192'd0, mem_burst_o}, {192'd0, pat[acc*64 +: 64]});
                if (mem_resp_i) acc++;
                tick();
            end
        end
        mem_resp_i = 1'b0;
        checkOutput("wb_resp_cycle10", {254'd0, line_resp_o, mem_write_o}, 256'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        $display("[TB] held request then back-to-back read");
        applyStimulus(1'b1, 1'b0, 32'h0000_2040, 256'd0);
        tick();
        contigBeats(16'h0101);
        checkOutput("held_resp", {255'd0, line_resp_o}, 256'd1);
        line_read_i = 1'b0;
        tick();
        checkOutput("held_idle", {255'd0, mem_read_o}, 256'd0);
        line_read_i = 1'b1;
        tick();
        checkOutput("second_burst", {255'd0, mem_read_o}, 256'd1);
        contigBeats(16'h0202);
        checkOutput("second_line", line_o, {{4{16'h0808}}, {4{16'h0606}}, {4{16'h0404}}, {4{16'h0202}}});
        line_read_i = 1'b0;
        tick();

        $display("[TB] read and write together");
        applyStimulus(1'b1, 1'b1, 32'h0000_3000, pat);
        tick();
        checkOutput("both_ctrl", {254'd0, mem_read_o, mem_write_o}, 256'd1);
        contigBeats(16'h0000);
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        $display("[TB] reset mid-fill");
        applyStimulus(1'b1, 1'b0, 32'h0000_8000, 256'd0);
        tick();
        mem_resp_i = 1'b1;
        mem_burst_i = 64'hDEAD_BEEF_0000_0001;
        tick();
        tick();
        rst = 1'b1;
        line_read_i = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("abort_line_o", line_o, 256'd0);
        checkOutput("abort_ctrl", {253'd0, mem_read_o, mem_write_o, line_resp_o}, 256'd0);
        repeat (3) tick();
        mem_resp_i = 1'b0;
        checkOutput("stray_idle", {253'd0, mem_read_o, mem_write_o, line_resp_o}, 256'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_9000, 256'd0);
        tick();
        contigBeats(16'h0A0A);
        checkOutput("after_abort_resp", {255'd0, line_resp_o}, 256'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        $display("[TB] stale-input isolation");
        lineA = randLine();
        applyStimulus(1'b0, 1'b1, 32'h0000_ABCD, lineA);
        tick();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, ~lineA);
        for (int k = 0; k < 4; k++) begin
            checkOutput("stale_burst", {192'd0, mem_burst_o}, {192'd0, lineA[k*64 +: 64]});
            checkOutput("stale_addr", {224'd0, mem_addr_o}, {224'd0, 32'h0000_ABC0});
            mem_resp_i = 1'b1;
            tick();
        end
        mem_resp_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        tick();

        $display("[TB] randomized transactions");
        for (int n = 0; n < 60; n++) runRandomTxn();

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the cache's 256-bit line port to the 64-bit burst physical-memory interface. A whole-line fill or writeback from the cache controller becomes exactly four 64-bit beats on memory. Fills are reassembled into one 256-bit line returned with a single-cycle response. Sits between the cache datapath's line storage and main memory. It is the memory-facing counterpart of the CPU-side word/byte extraction and merge logic.

## Interface
Parameters:
- none. Line width is fixed at 256, beat width at 64, and four beats per line.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- line_read_i  input  1  cache requests a line fill; held until line_resp_o.
- line_write_i  input  1  cache requests a line writeback; held until line_resp_o.
- line_addr_i  input  32  line address; bits [4:0] ignored.
- line_i  input  256  line to write back; sampled at request acceptance.
- line_o  output  256  assembled fill line; valid when line_resp_o=1, held until next fill completes.
- line_resp_o  output  1  one-cycle completion pulse for either request type.
- mem_addr_o  output  32  {latched line_addr_i[31:5], 5'b0}.
- mem_read_o  output  1  burst read request.
- mem_write_o  output  1  burst write request.
- mem_burst_i  input  64  read beat data; valid when mem_resp_i=1.
- mem_burst_o  output  64  current write beat.
- mem_resp_i  input  1  memory beat strobe: read beat valid, or write beat accepted.

## Operation
- FSM states: IDLE, RD, RD_DONE, WR, WR_DONE. A 2-bit beat counter tracks progress.
- IDLE:
  - write_i=1: latch the address and line_i, clear the counter, go to WR.
  - Otherwise read_i=1: latch the address, clear the counter, go to RD.
  - write_i has priority if both are asserted; both asserted together is illegal from the cache.
  - mem_resp_i is ignored in IDLE.
- RD:
  - mem_read_o=1 throughout.
  - Each cycle with mem_resp_i=1, store mem_burst_i into line bits [64k+63:64k] for k=counter, then increment the counter.
  - On the beat with counter=3, go to RD_DONE.
- RD_DONE: line_resp_o=1, mem_read_o=0, line_o shows the full line; next state is IDLE.
- WR:
  - mem_write_o=1 throughout.
  - mem_burst_o = latched line[64k+63:64k] for k=counter.
  - On mem_resp_i=1, increment the counter; on the beat with counter=3, go to WR_DONE.
- WR_DONE: line_resp_o=1, mem_write_o=0; next state is IDLE.
- Beat order is ascending: beat 0 = bits [63:0], beat 3 = bits [255:192].
- Beats need not be contiguous. Cycles with mem_resp_i=0 stall the counter.
- mem_addr_o stays constant for the whole transaction.
- The cache drops its request in the cycle after line_resp_o, so IDLE following a DONE state never re-triggers.
- Changes to line_i or line_addr_i after acceptance have no effect on the transaction in flight.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - mem_read_o=0, mem_write_o=0, line_resp_o=0.
  - mem_addr_o=0, mem_burst_o=0, line_o=0.
- Reset mid-transaction aborts immediately: the next cycle is IDLE with reset values.
- Memory beats arriving after an abort are ignored, and no line_resp_o is issued.
- Request sampled at edge E; mem_read_o/mem_write_o are high from cycle E+1.
- With contiguous resp_i in cycles t..t+3, line_resp_o is high in cycle t+4 only.
- Minimum request-to-response latency: 6 cycles, i.e. request cycle, 4 beats, DONE.
- All outputs are registered state or decoded from state. There is no combinational path from mem_resp_i to any output except through state.
- line_o updates only during RD beats. Between fills it holds the last completed line; a partial fill aborted by reset is cleared to 0.

## Test plan
- Read fill: line_addr_i=0x0000_1234, read_i=1; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… contiguously.
  - mem_addr_o=0x0000_1220.
  - line_o={0x4444…,0x3333…,0x2222…,0x1111…}.
  - One-cycle line_resp_o, 6 cycles after the request.
- Writeback: line_i=256'h{…}03_02_01_00 pattern, write_i=1, memory accepts with gaps (resp_i in cycles 2, 5, 6, 9).
  - mem_burst_o steps through line_i[63:0]…[255:192] only on accepted beats.
  - mem_write_o falls with line_resp_o in cycle 10.
- Held request: cache keeps read_i asserted until the cycle after line_resp_o.
  - Exactly one burst is issued; the adapter returns to IDLE.
  - A new read_i issued 1 cycle later starts a second burst cleanly.
- Both read_i and write_i asserted: a write burst executes and mem_read_o never rises.
- Reset after beat 2 of a fill:
  - Outputs return to reset values the next cycle and line_o=0.
  - Stray resp_i pulses in IDLE cause no state change.
  - A following read completes normally.
- Stale-input isolation: change line_i and line_addr_i during WR. mem_addr_o and the remaining beats must reflect the values latched at acceptance.
